// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared types and helpers for the video RAM controller
package vram_pkg;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_t;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/vram_dpram.sv
// rtl/vram_dpram.sv - inferred dual-port RAM: port A read-only, port B byte-enable write / read
module vram_dpram
  import vram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  localparam int BE_W  = be_width(DATA_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_en,
  output logic [DATA_W-1:0] a_data,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [BE_W-1:0]   b_be,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Array contents are never reset; only the output registers are.
  always_ff @(posedge clock) begin
    if (b_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (b_be[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
      end
    end
  end

  // Non-blocking reads of mem give old data when port B writes the same word.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_data  <= '0;
      b_rdata <= '0;
    end else begin
      if (a_en) a_data  <= mem[a_addr];
      if (b_en) b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/vram_ctrl.sv
// rtl/vram_ctrl.sv - frame buffer VRAM: display readout port, Avalon-MM port, clear engine
// Clear engine is built only when VRAM_CLEAR_EN is defined.
module vram_ctrl
  import vram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     readout_addr,
  input  logic                  readout_en,
  output logic [DATA_W-1:0]     readout_data,
  output logic                  readout_valid,
  input  logic [ADDR_W-1:0]     avl_addr,
  input  logic                  avl_read,
  input  logic                  avl_write,
  input  logic [DATA_W/8-1:0]   avl_byteenable,
  input  logic [DATA_W-1:0]     avl_writedata,
  output logic [DATA_W-1:0]     avl_readdata,
  output logic                  avl_readdatavalid,
  output logic                  avl_waitrequest,
  input  logic                  clear_start,
  input  logic [DATA_W-1:0]     clear_value,
  output logic                  clear_busy
);

  localparam int BE_W = be_width(DATA_W);

  logic              clr_run;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_value;

`ifdef VRAM_CLEAR_EN
  clr_state_t state;

  // clear_start is only looked at in IDLE, so a second start mid-fill is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= CLR_IDLE;
      clr_addr  <= '0;
      clr_value <= '0;
    end else begin
      case (state)
        CLR_IDLE: begin
          if (clear_start) begin
            state     <= CLR_RUN;
            clr_addr  <= '0;
            clr_value <= clear_value;
          end
        end
        CLR_RUN: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == '1) state <= CLR_IDLE;
        end
      endcase
    end
  end

  assign clr_run = (state == CLR_RUN);
`else
  logic unused_clear;
  assign unused_clear = ^{clear_start, clear_value};
  assign clr_run   = 1'b0;
  assign clr_addr  = '0;
  assign clr_value = '0;
`endif

  assign clear_busy      = clr_run;
  assign avl_waitrequest = clr_run;

  // A simultaneous read and write performs only the write.
  logic wr_acc;
  logic rd_acc;
  assign wr_acc = avl_write & ~clr_run;
  assign rd_acc = avl_read & ~avl_write & ~clr_run;

  logic [ADDR_W-1:0] b_addr;
  logic              b_we;
  logic [BE_W-1:0]   b_be;
  logic [DATA_W-1:0] b_wdata;

  assign b_addr  = clr_run ? clr_addr  : avl_addr;
  assign b_we    = clr_run | wr_acc;
  assign b_be    = clr_run ? '1        : avl_byteenable;
  assign b_wdata = clr_run ? clr_value : avl_writedata;

  always_ff @(posedge clock) begin
    if (reset) begin
      readout_valid     <= 1'b0;
      avl_readdatavalid <= 1'b0;
    end else begin
      readout_valid     <= readout_en;
      avl_readdatavalid <= rd_acc;
    end
  end

  vram_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .a_addr  (readout_addr),
    .a_en    (readout_en),
    .a_data  (readout_data),
    .b_addr  (b_addr),
    .b_en    (rd_acc),
    .b_we    (b_we),
    .b_be    (b_be),
    .b_wdata (b_wdata),
    .b_rdata (avl_readdata)
  );

endmodule

// File: tb/tb_vram_ctrl.sv
// tb/tb_vram_ctrl.sv - directed checks for vram_ctrl; clear-engine cases run when VRAM_CLEAR_EN is defined
module tb_vram_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int BE_W   = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] readout_addr;
  logic              readout_en;
  logic [DATA_W-1:0] readout_data;
  logic              readout_valid;
  logic [ADDR_W-1:0] avl_addr;
  logic              avl_read;
  logic              avl_write;
  logic [BE_W-1:0]   avl_byteenable;
  logic [DATA_W-1:0] avl_writedata;
  logic [DATA_W-1:0] avl_readdata;
  logic              avl_readdatavalid;
  logic              avl_waitrequest;
  logic              clear_start;
  logic [DATA_W-1:0] clear_value;
  logic              clear_busy;

  int nvec = 0;
  int nerr = 0;

  vram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock             (clock),
    .reset             (reset),
    .readout_addr      (readout_addr),
    .readout_en        (readout_en),
    .readout_data      (readout_data),
    .readout_valid     (readout_valid),
    .avl_addr          (avl_addr),
    .avl_read          (avl_read),
    .avl_write         (avl_write),
    .avl_byteenable    (avl_byteenable),
    .avl_writedata     (avl_writedata),
    .avl_readdata      (avl_readdata),
    .avl_readdatavalid (avl_readdatavalid),
    .avl_waitrequest   (avl_waitrequest),
    .clear_start       (clear_start),
    .clear_value       (clear_value),
    .clear_busy        (clear_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic avl_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
    avl_addr = a; avl_writedata = d; avl_byteenable = be; avl_write = 1'b1;
    step();
    avl_write = 1'b0; avl_byteenable = '0;
  endtask

  task automatic avl_rd(input logic [ADDR_W-1:0] a, output logic [31:0] d, output logic v);
    avl_addr = a; avl_read = 1'b1;
    step();
    d = avl_readdata; v = avl_readdatavalid;
    avl_read = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while (clear_busy && g < 100) begin
      step();
      g++;
    end
    check(tag, {31'd0, clear_busy}, 32'd0);
  endtask

  logic [31:0] d;
  logic        v;
  int          cnt;
  int          bad;
  int          guard;
  logic        ro;

  initial begin
    reset = 1'b1;
    readout_addr = '0; readout_en = 1'b0;
    avl_addr = '0; avl_read = 1'b0; avl_write = 1'b0;
    avl_byteenable = '0; avl_writedata = '0;
    clear_start = 1'b0; clear_value = '0;
    repeat (2) step();
    reset = 1'b0;
    check("rst_readout_data", readout_data, 32'h0);
    check("rst_readout_valid", {31'd0, readout_valid}, 32'd0);
    check("rst_readdata", avl_readdata, 32'h0);
    check("rst_readdatavalid", {31'd0, avl_readdatavalid}, 32'd0);
    check("rst_waitrequest", {31'd0, avl_waitrequest}, 32'd0);
    check("rst_busy", {31'd0, clear_busy}, 32'd0);

    // Byte-lane merge, then read latency 1 with a single-cycle valid pulse
    avl_wr(5, 32'hDEADBEEF, 4'hF);
    avl_wr(5, 32'h00001200, 4'h2);
    avl_rd(5, d, v);
    check("be_merge_valid", {31'd0, v}, 32'd1);
    check("be_merge_data", d, 32'hDEAD12EF);
    step();
    check("rdv_one_cycle", {31'd0, avl_readdatavalid}, 32'd0);

    avl_wr(9, 32'h01234567, 4'hF);
    avl_wr(9, 32'hAABBCCDD, 4'h9);
    avl_rd(9, d, v);
    check("be_lanes_0_3", d, 32'hAA2345DD);

    // Readout sees old data when port B writes the same word that cycle
    readout_addr = 5; readout_en = 1'b1;
    avl_wr(5, 32'h11111111, 4'hF);
    check("collide_old_data", readout_data, 32'hDEAD12EF);
    check("collide_valid", {31'd0, readout_valid}, 32'd1);
    step();
    check("readout_new_data", readout_data, 32'h11111111);
    readout_en = 1'b0; readout_addr = 9;
    step();
    check("readout_valid_low", {31'd0, readout_valid}, 32'd0);
    check("readout_hold", readout_data, 32'h11111111);

    // Read and write together: write lands, no valid pulse
    avl_wr(3, 32'h33333333, 4'hF);
    avl_addr = 3; avl_writedata = 32'hCAFEF00D; avl_byteenable = 4'hF;
    avl_read = 1'b1; avl_write = 1'b1;
    step();
    avl_read = 1'b0; avl_write = 1'b0; avl_byteenable = '0;
    check("rw_no_valid", {31'd0, avl_readdatavalid}, 32'd0);
    step();
    check("rw_no_valid_late", {31'd0, avl_readdatavalid}, 32'd0);
    avl_rd(3, d, v);
    check("rw_write_landed", d, 32'hCAFEF00D);
    check("rw_read_valid", {31'd0, v}, 32'd1);

`ifdef VRAM_CLEAR_EN
    // Clear start with a same-cycle read: read is still accepted
    clear_start = 1'b1; clear_value = 32'hA5A5A5A5;
    avl_addr = 5; avl_read = 1'b1;
    step();
    check("start_cycle_rdv", {31'd0, avl_readdatavalid}, 32'd1);
    check("start_cycle_data", avl_readdata, 32'h11111111);
    check("busy_first", {31'd0, clear_busy}, 32'd1);
    check("wait_first", {31'd0, avl_waitrequest}, 32'd1);
    clear_start = 1'b0;
    avl_addr = 2;
    cnt = 1; bad = 0; guard = 0;
    while (clear_busy && guard < 40) begin
      ro = (cnt == 3);
      clear_start = ro;
      clear_value = ro ? 32'h0 : 32'hA5A5A5A5;
      readout_en = ro; readout_addr = 0;
      step();
      guard++;
      if (ro) check("readout_during_clear", readout_data, 32'hA5A5A5A5);
      if (clear_busy) begin
        cnt++;
        if (!avl_waitrequest || avl_readdatavalid) bad++;
      end
    end
    clear_start = 1'b0; readout_en = 1'b0;
    check("busy_cycles", cnt, 16);
    check("wait_during_clear", bad, 0);
    check("wait_after_clear", {31'd0, avl_waitrequest}, 32'd0);
    step();
    avl_read = 1'b0;
    check("pending_read_valid", {31'd0, avl_readdatavalid}, 32'd1);
    check("pending_read_data", avl_readdata, 32'hA5A5A5A5);
    for (int i = 0; i < DEPTH; i++) begin
      avl_rd(i[ADDR_W-1:0], d, v);
      check($sformatf("fill_a5_%0d", i), d, 32'hA5A5A5A5);
    end

    // Reset in the middle of a clear
    clear_start = 1'b1; clear_value = 32'hFFFFFFFF;
    step();
    clear_start = 1'b0;
    wait_idle("fill_ff_done");
    clear_start = 1'b1; clear_value = 32'h0;
    step();
    clear_start = 1'b0;
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, clear_busy}, 32'd0);
    check("rst_mid_wait", {31'd0, avl_waitrequest}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      avl_rd(i[ADDR_W-1:0], d, v);
      if (i < 7)
        check($sformatf("rst_cleared_%0d", i), d, 32'h0);
      else if (i == 7)
        check("rst_boundary_7", {31'd0, (d == 32'h0 || d == 32'hFFFFFFFF)}, 32'd1);
      else
        check($sformatf("rst_untouched_%0d", i), d, 32'hFFFFFFFF);
    end
`else
    // Without the clear engine, clear_start has no effect
    clear_start = 1'b1; clear_value = 32'h0;
    step();
    clear_start = 1'b0;
    check("noclr_busy", {31'd0, clear_busy}, 32'd0);
    check("noclr_wait", {31'd0, avl_waitrequest}, 32'd0);
    step();
    avl_rd(5, d, v);
    check("noclr_mem_kept", d, 32'h11111111);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/vram_ctrl.md
# vram_ctrl

Parametrised dual-port video RAM for the frame buffer path. Port A is a read-only pixel readout port for the display scanner. Port B is an Avalon-MM slave with byte enables, explicit read-data-valid and wait-request. A hardware clear engine fills the whole memory with one word at 1 word/cycle, without CPU writes.

## Interface
- DATA_W, 32, word width in bits; multiple of 8
- ADDR_W, 11, word address width; depth = 2^ADDR_W words
- clock  in  1  single clock for all logic and both RAM ports
- reset  in  1  synchronous, active-high
- readout_addr  in  ADDR_W  display read address
- readout_en  in  1  display read request
- readout_data  out  DATA_W  display read data
- readout_valid  out  1  readout_data valid this cycle
- avl_addr  in  ADDR_W  Avalon word address
- avl_read  in  1  Avalon read
- avl_write  in  1  Avalon write
- avl_byteenable  in  DATA_W/8  write byte lanes
- avl_writedata  in  DATA_W  write data
- avl_readdata  out  DATA_W  read data
- avl_readdatavalid  out  1  one-cycle pulse per accepted read
- avl_waitrequest  out  1  transfer not accepted this cycle
- clear_start  in  1  start fill (pulse or level)
- clear_value  in  DATA_W  fill word, sampled at start
- clear_busy  out  1  fill in progress

## Operation
- Clock and reset: one clock; reset is synchronous and active-high.
- Readout: when readout_en=1, the word at readout_addr is registered into readout_data. readout_data holds its value when readout_en=0.
- Avalon accept rule: a transfer is accepted when avl_read or avl_write is high and avl_waitrequest=0.
- Accepted write: only the lanes with avl_byteenable bits set are written.
- Accepted read: returns the full word.
- avl_read and avl_write both high: the write is performed, the read is dropped, and no readdatavalid is produced.
- Mixed-port collision (port A reads the address port B writes in the same cycle): port A returns the old data.
- Clear FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR on clear_start=1. clear_value is latched and the address counter is set to 0.
  - CLEAR: writes the latched value to the counter address with all byte lanes enabled, then increments the counter.
  - CLEAR -> IDLE on the cycle after the write to address 2^ADDR_W-1.
- clear_start while in CLEAR is ignored; there is no restart.
- While in CLEAR: avl_waitrequest=1 (combinational from state), clear_busy=1.
- Readout port during CLEAR: stays fully functional and returns whatever the contents are at that moment.
- Reset in the middle of a clear: FSM goes to IDLE and the counter to 0. Words already written stay cleared and the rest are untouched. Memory contents are never reset.

## Timing
- Readout latency 1: readout_en at cycle N gives readout_valid=1 and the data at N+1.
- Avalon read latency 1: a read accepted at N gives avl_readdatavalid=1 at N+1 for exactly one cycle.
- Avalon write takes effect at the edge ending cycle N; a read of the same address at N+1 returns the new data.
- clear_start at cycle N in IDLE:
  - clear_busy=1 and avl_waitrequest=1 from N+1 through N+2^ADDR_W.
  - Addresses 0..2^ADDR_W-1 are written in cycles N+1..N+2^ADDR_W.
  - IDLE again at N+2^ADDR_W+1.
- Avalon transfer in the same cycle as clear_start in IDLE: the transfer is accepted, because waitrequest is still 0. A read accepted that cycle still gets its readdatavalid at N+1.
- Reset values: readout_data=0, readout_valid=0, avl_readdata=0, avl_readdatavalid=0, avl_waitrequest=0, clear_busy=0.

## Configuration
- VRAM_CLEAR_EN defined: the clear FSM, counter and value latch are built as described above.
- VRAM_CLEAR_EN undefined:
  - clear_start and clear_value are ignored.
  - clear_busy and avl_waitrequest are tied to 0.
  - The port list is unchanged.

## Structure
- vram_pkg holds:
  - the clear state enum (CLR_IDLE, CLR_RUN);
  - the function deriving the byte-enable width from DATA_W.
- Sub-module vram_dpram: inferred true dual-port RAM.
  - One clock, synchronous reads, byte-enable writes on port B.
  - Old-data mixed-port read-during-write.
- vram_ctrl holds the port B mux (Avalon vs. clear engine), the valid pipelines and the FSM.

## Test plan
- Write 0xDEADBEEF to address 5 with byteenable=0xF, then byteenable=0x2 with data 0x00001200, then read address 5 -> readdatavalid at +1 cycle, data 0xDEAD12EF.
- Readout address 5 with readout_en=1 in the same cycle as an Avalon write of 0x11111111 to address 5 -> readout_data returns the old value; the next readout returns 0x11111111.
- clear_start with clear_value=0xA5A5A5A5 (ADDR_W=4):
  - busy and waitrequest high for exactly 16 cycles;
  - an Avalon read held pending during the clear is accepted on the first cycle after;
  - all 16 words read back 0xA5A5A5A5.
- clear_start again at the 3rd CLEAR cycle -> ignored; still 16 cycles total.
- Reset asserted at CLEAR cycle 8 (ADDR_W=4, fill 0x0, prior contents 0xFF..):
  - next cycle busy=0 and waitrequest=0;
  - words 0..6 or 0..7 (per the cycle boundary) read 0x0 and the rest read 0xFFFFFFFF.
- avl_read and avl_write both high to address 3 -> the write lands and no readdatavalid pulse follows.
